// File: rtl/aes_pkg.sv
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES constants, SubBytes FSM state type and GF(2^8)
//                helper functions used by the serial SubBytes block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  // Direction select: forward S-box for encryption, inverse for decryption
  localparam logic AES_ENC = 1'b0;
  localparam logic AES_DEC = 1'b1;

  // Serial SubBytes controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } aes_sb_state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] aes_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    logic [7:0] bb;
    acc = 8'h00;
    aa  = a;
    bb  = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) begin
        acc = acc ^ aa;
      end
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires)
  function automatic logic [7:0] aes_gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = aes_gf_mul(x, x);
    x3   = aes_gf_mul(x2, x);
    x6   = aes_gf_mul(x3, x3);
    x12  = aes_gf_mul(x6, x6);
    x15  = aes_gf_mul(x12, x3);
    x30  = aes_gf_mul(x15, x15);
    x60  = aes_gf_mul(x30, x30);
    x120 = aes_gf_mul(x60, x60);
    x240 = aes_gf_mul(x120, x120);
    x252 = aes_gf_mul(x240, x12);
    return aes_gf_mul(x252, x2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox_lut.sv
// ============================================================================
//  Module      : aes_sbox_lut
//  Description : Single-byte AES S-box / inverse S-box. Computed as field
//                inversion plus affine map rather than a stored table, so the
//                forward and inverse directions share one inverter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic       mode_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  logic [7:0] w_inv_aff;
  logic [7:0] w_inv_in;
  logic [7:0] w_inv_out;
  logic [7:0] w_fwd_aff;

  // Inverse affine map (undo the forward affine before inverting)
  assign w_inv_aff = {data_i[6:0], data_i[7]}
                   ^ {data_i[4:0], data_i[7:5]}
                   ^ {data_i[1:0], data_i[7:2]}
                   ^ 8'h05;

  assign w_inv_in  = (mode_i == AES_DEC) ? w_inv_aff : data_i;
  assign w_inv_out = aes_gf_inv(w_inv_in);

  // Forward affine map applied after inversion
  assign w_fwd_aff = w_inv_out
                   ^ {w_inv_out[6:0], w_inv_out[7]}
                   ^ {w_inv_out[5:0], w_inv_out[7:6]}
                   ^ {w_inv_out[4:0], w_inv_out[7:5]}
                   ^ {w_inv_out[3:0], w_inv_out[7:4]}
                   ^ 8'h63;

  assign data_o = (mode_i == AES_DEC) ? w_inv_out : w_fwd_aff;

endmodule

`default_nettype wire

// File: rtl/aes_sub_bytes_serial.sv
// ============================================================================
//  Module      : aes_sub_bytes_serial
//  Description : Serial AES SubBytes/InvSubBytes over a 128-bit state with
//                valid/ready handshakes on both sides. One byte per cycle by
//                default; defining AES_SUB_BYTES_DUAL_SBOX_EN processes two
//                bytes per cycle with two S-box instances.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sub_bytes_serial
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         mode_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o
);

`ifdef AES_SUB_BYTES_DUAL_SBOX_EN
  localparam int         c_NUM_SBOX = 2;
`else
  localparam int         c_NUM_SBOX = 1;
`endif
  localparam logic [3:0] c_CNT_STEP = 4'(c_NUM_SBOX);
  localparam logic [3:0] c_CNT_LAST = 4'(16 - c_NUM_SBOX);

  aes_sb_state_e r_st;
  aes_sb_state_e w_st_next;
  logic [127:0]  r_data;
  logic [3:0]    r_cnt;
  logic          r_mode;
  logic          r_armed;

  logic          w_in_ready;
  logic          w_in_hs;
  logic          w_out_hs;
  logic [127:0]  w_sub_data;
  logic [3:0]    w_lane_idx  [c_NUM_SBOX];
  logic [7:0]    w_lane_byte [c_NUM_SBOX];
  logic [7:0]    w_lane_sub  [c_NUM_SBOX];

  // One S-box per lane; lane g works on byte cnt+g
  for (genvar g = 0; g < c_NUM_SBOX; g++) begin : g_sbox
    assign w_lane_idx[g]  = r_cnt + 4'(g);
    assign w_lane_byte[g] = r_data[{w_lane_idx[g], 3'b000} +: 8];

    aes_sbox_lut u_sbox (
      .mode_i (r_mode),
      .data_i (w_lane_byte[g]),
      .data_o (w_lane_sub[g])
    );
  end

  // Merge substituted lane bytes back into the state word
  always_comb begin
    w_sub_data = r_data;
    for (int l = 0; l < c_NUM_SBOX; l++) begin
      w_sub_data[{w_lane_idx[l], 3'b000} +: 8] = w_lane_sub[l];
    end
  end

  assign w_in_hs  = in_valid_i & w_in_ready;
  assign w_out_hs = out_valid_o & out_ready_i;

  // Keeps in_ready low until the first edge after reset is released
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_st <= ST_IDLE;
    end else begin
      r_st <= w_st_next;
    end
  end

  // FSM next-state logic; clear overrides every other event
  always_comb begin
    w_st_next = r_st;
    if (clear_i) begin
      w_st_next = ST_IDLE;
    end else begin
      case (r_st)
        ST_IDLE: if (w_in_hs)             w_st_next = ST_SUB;
        ST_SUB:  if (r_cnt == c_CNT_LAST) w_st_next = ST_DONE;
        ST_DONE: if (out_ready_i)         w_st_next = ST_IDLE;
        default:                          w_st_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; data_o is forced to zero unless a result is on offer
  always_comb begin
    w_in_ready  = (r_st == ST_IDLE) & r_armed;
    in_ready_o  = w_in_ready;
    out_valid_o = (r_st == ST_DONE);
    busy_o      = (r_st == ST_SUB) | (r_st == ST_DONE);
    data_o      = out_valid_o ? r_data : 128'h0;
  end

  // Datapath: capture on accept, substitute during SUB, wipe on hand-off
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data <= 128'h0;
      r_cnt  <= 4'd0;
      r_mode <= AES_ENC;
    end else if (clear_i) begin
      r_data <= 128'h0;
      r_cnt  <= 4'd0;
      r_mode <= AES_ENC;
    end else begin
      case (r_st)
        ST_IDLE: begin
          if (w_in_hs) begin
            r_data <= data_i;
            r_mode <= mode_i;
            r_cnt  <= 4'd0;
          end
        end
        ST_SUB: begin
          r_data <= w_sub_data;
          r_cnt  <= r_cnt + c_CNT_STEP;
        end
        ST_DONE: begin
          if (w_out_hs) begin
            r_data <= 128'h0;
          end
        end
        default: begin
          r_data <= 128'h0;
          r_cnt  <= 4'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_sub_bytes_serial.sv
// ============================================================================
//  Module      : tb_aes_sub_bytes_serial
//  Description : Self-checking bench for aes_sub_bytes_serial with a table
//                based S-box reference built from first principles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_sub_bytes_serial;

`ifdef AES_SUB_BYTES_DUAL_SBOX_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] t_fwd [256];
  logic [7:0] t_inv [256];

  aes_sub_bytes_serial dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_i      (din),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (dout),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Forward S-box: brute-force field inverse, then bitwise affine transform
  function automatic logic [7:0] ref_sbox(input logic [7:0] v);
    logic [7:0] inv = 8'h00;
    logic [7:0] c   = 8'h63;
    logic [7:0] b;
    for (int y = 1; y < 256; y++) begin
      if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
    end
    for (int i = 0; i < 8; i++) begin
      b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
           ^ inv[(i + 7) % 8] ^ c[i];
    end
    return b;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      t_fwd[x] = ref_sbox(8'(x));
    end
    for (int x = 0; x < 256; x++) begin
      t_inv[t_fwd[x]] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic m, input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = m ? t_inv[d[8*k +: 8]] : t_fwd[d[8*k +: 8]];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one input and let it be accepted on the next edge
  task automatic start_op(input logic m, input logic [127:0] d);
    check("in_ready_before_accept", in_ready, 1'b1);
    mode     = m;
    din      = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for the result (scrambling mode/data meanwhile), hold off, hand off
  task automatic finish_op(input logic [127:0] exp, input int bp);
    int n = 0;
    while (!out_valid && n < 60) begin
      check("busy_during_sub", busy, 1'b1);
      mode = 1'($urandom);
      din  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    check("latency", 128'(n), 128'(LAT));
    check("result", dout, exp);
    for (int i = 0; i < bp; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      din       = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check("hold_data", dout, exp);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_valid", out_valid, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_valid", out_valid, 1'b0);
    check("post_data", dout, 128'h0);
    check("post_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic         m;
    logic [127:0] d;
    int           seen;

    rst       = 1'b1;
    clear     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = 128'h0;
    build_tables();

    // Reset values while reset is held
    #3;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", dout, 128'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rel_in_ready_pre_edge", in_ready, 1'b0);
    tick();
    check("rel_in_ready", in_ready, 1'b1);

    // Known vectors, first one with 10 cycles of backpressure
    start_op(1'b0, 128'hffeeddccbbaa99887766554433221100);
    finish_op(128'h1628c14beaaceec4f533fc1bc3938263, 10);
    start_op(1'b1, 128'h1628c14beaaceec4f533fc1bc3938263);
    finish_op(128'hffeeddccbbaa99887766554433221100, 0);
    start_op(1'b0, 128'h0);
    finish_op({16{8'h63}}, 1);

    // Randomized operations against the reference tables
    for (int t = 0; t < 24; t++) begin
      m = 1'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      start_op(m, d);
      finish_op(ref_sub(m, d), int'($urandom_range(0, 3)));
    end

    // Clear in the middle of SUB aborts the operation
    start_op(1'b0, {$urandom, $urandom, $urandom, $urandom});
    repeat (5) tick();
    clear = 1'b1;
    in_valid = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_in_ready", in_ready, 1'b1);
    check("clear_busy", busy, 1'b0);
    check("clear_data", dout, 128'h0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("clear_no_valid", 128'(seen), 128'h0);
    d = {$urandom, $urandom, $urandom, $urandom};
    start_op(1'b1, d);
    finish_op(ref_sub(1'b1, d), 2);

    // Asynchronous reset between edges in the middle of SUB
    start_op(1'b0, {$urandom, $urandom, $urandom, $urandom});
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_data", dout, 128'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("arst_rel_pre_edge", in_ready, 1'b0);
    tick();
    check("arst_rel_in_ready", in_ready, 1'b1);
    check("arst_rel_valid", out_valid, 1'b0);
    d = {$urandom, $urandom, $urandom, $urandom};
    start_op(1'b0, d);
    finish_op(ref_sub(1'b0, d), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
